// File: rtl/spi_master_mc.sv
// Multi-mode SPI master: CPOL/CPHA modes, runtime SCLK divider, MSB/LSB-first order,
// one-hot active-low chip selects with programmable setup/hold around each frame.
module spi_master_mc #(
  parameter  int SPI_MAXLEN = 32,
  parameter  int NUM_SS     = 4,
  parameter  int DIV_WIDTH  = 8,
  localparam int CW         = $clog2(SPI_MAXLEN) + 1,
  localparam int SSW        = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start_cmd,
  output logic                  spi_rdy,
  output logic                  done,
  input  logic [CW-1:0]         n_clks,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  output logic [SPI_MAXLEN-1:0] rx_miso,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [SSW-1:0]        ss_sel,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_SS-1:0]     SS_N
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  localparam logic [CW-1:0]        MAXLEN_C = CW'(SPI_MAXLEN);
  localparam logic [CW-1:0]        BIT_ONE  = CW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [SSW:0]         NUM_SS_C = (SSW + 1)'(NUM_SS);

  state_e                  state_q, state_d;
  logic [CW-1:0]           n_q, n_d, bits_q, bits_d;
  logic [SPI_MAXLEN-1:0]   tx_q, tx_d, rx_q, rx_d, rxo_q, rxo_d;
  logic                    cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DIV_WIDTH-1:0]    h_q, h_d, div_q, div_d;
  logic                    sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic [NUM_SS-1:0]       ssn_q, ssn_d;

  logic                    legal, cur_bit, first_bit;
  logic [SPI_MAXLEN-1:0]   tx_shift, rx_shift, tx_aln, tx_aln_sh;
  logic [DIV_WIDTH-1:0]    h_in;
  logic [NUM_SS-1:0]       onehot;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      n_q     <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxo_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      h_q     <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      ssn_q   <= '1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxo_q   <= rxo_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      h_q     <= h_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      ssn_q   <= ssn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxo_d   = rxo_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    h_d     = h_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    ssn_d   = ssn_q;

    for (int unsigned i = 0; i < NUM_SS; i++) onehot[i] = (ss_sel == SSW'(i));
    legal = (n_clks != '0) && (n_clks <= MAXLEN_C) && ({1'b0, ss_sel} < NUM_SS_C);
    h_in  = (clk_div == '0) ? DIV_ONE : clk_div;

    // TX is normalised so the next bit is always at bit 0 (LSB-first) or the top bit (MSB-first)
    tx_aln    = lsb_first ? tx_data : (tx_data << (MAXLEN_C - n_clks));
    first_bit = lsb_first ? tx_aln[0] : tx_aln[SPI_MAXLEN-1];
    tx_aln_sh = lsb_first ? (tx_aln >> 1) : (tx_aln << 1);
    cur_bit   = lsb_q ? tx_q[0] : tx_q[SPI_MAXLEN-1];
    tx_shift  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    rx_shift  = lsb_q ? {MISO, rx_q[SPI_MAXLEN-1:1]} : {rx_q[SPI_MAXLEN-2:0], MISO};

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start_cmd && legal) begin
          state_d = SETUP;
          n_d     = n_clks;
          bits_d  = n_clks;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          h_d     = h_in;
          div_d   = h_in;
          rx_d    = '0;
          ssn_d   = ~onehot;
          if (!cpha) begin
            mosi_d = first_bit;
            tx_d   = tx_aln_sh;
          end else begin
            tx_d   = tx_aln;
          end
        end
      end
      SETUP, XFER: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_ONE;
        end else begin
          div_d = h_q - DIV_ONE;
          if (sclk_q == cpol_q) begin
            // At idle level: either a leading edge for the next bit or the end of the frame
            if (bits_q != '0) begin
              state_d = XFER;
              sclk_d  = ~cpol_q;
              if (cpha_q) begin
                mosi_d = cur_bit;
                tx_d   = tx_shift;
              end else begin
                rx_d   = rx_shift;
              end
            end else begin
              state_d = HOLD;
            end
          end else begin
            sclk_d = cpol_q;
            bits_d = bits_q - BIT_ONE;
            if (cpha_q) begin
              rx_d = rx_shift;
            end else if (bits_q != BIT_ONE) begin
              mosi_d = cur_bit;
              tx_d   = tx_shift;
            end
          end
        end
      end
      HOLD: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_ONE;
        end else begin
          state_d = IDLE;
          ssn_d   = '1;
          done_d  = 1'b1;
          rxo_d   = lsb_q ? (rx_q >> (MAXLEN_C - n_q)) : rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi_rdy = (state_q == IDLE);
  assign done    = done_q;
  assign rx_miso = rxo_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS_N    = ssn_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: a behavioural SPI slave checks MOSI/MISO bit order,
// while the main sequence checks frame length, chip selects, done and rx_miso.
module tb_spi_master_mc;

  logic        clk = 1'b0;
  logic        areset;
  logic        start_cmd;
  logic        spi_rdy;
  logic        done;
  logic [5:0]  n_clks;
  logic [31:0] tx_data;
  logic [31:0] rx_miso;
  logic        cpol, cpha, lsb_first;
  logic [7:0]  clk_div;
  logic [1:0]  ss_sel;
  logic        SCLK, MOSI, MISO;
  logic [3:0]  SS_N;

  int          checks = 0;
  int          errors = 0;

  logic        m_cpol, m_cpha, m_lsb;
  int          m_n;
  logic [31:0] s_miso_pat, s_rx_word;
  int          s_idx, s_rx_cnt;

  spi_master_mc #(.SPI_MAXLEN(32), .NUM_SS(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .areset(areset), .start_cmd(start_cmd), .spi_rdy(spi_rdy), .done(done),
    .n_clks(n_clks), .tx_data(tx_data), .rx_miso(rx_miso), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .SS_N(SS_N)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic pat_bit(input int k);
    return m_lsb ? s_miso_pat[k] : s_miso_pat[m_n-1-k];
  endfunction

  // Slave: samples MOSI and updates MISO on the edges opposite to each other
  always @(SCLK) begin
    if (SS_N !== 4'hF && areset !== 1'b1) begin
      if ((SCLK !== m_cpol) == (m_cpha == 1'b0)) begin
        if (s_rx_cnt < 32) begin
          if (m_lsb) s_rx_word[s_rx_cnt] = MOSI;
          else       s_rx_word = {s_rx_word[30:0], MOSI};
        end
        s_rx_cnt++;
      end else begin
        if (s_idx < m_n) MISO = pat_bit(s_idx);
        s_idx++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input logic c_pol, input logic c_pha,
                           input logic lsb, input int n, input logic [31:0] tx,
                           input logic [31:0] pat, input logic [7:0] dv, input logic [1:0] ss);
    int          h, lowcnt;
    logic        ssbad, donebad;
    logic [31:0] mask;
    logic [3:0]  exp_ss;
    h      = (dv == 8'd0) ? 1 : int'(dv);
    mask   = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    exp_ss = ~(4'b0001 << ss);
    cpol = c_pol; cpha = c_pha; lsb_first = lsb;
    m_cpol = c_pol; m_cpha = c_pha; m_lsb = lsb; m_n = n; s_miso_pat = pat;
    repeat (2) @(negedge clk);
    check({tag, "_sclk_idle_pre"}, SCLK, c_pol);
    s_rx_word = '0; s_rx_cnt = 0;
    if (!c_pha) begin MISO = pat_bit(0); s_idx = 1; end
    else s_idx = 0;
    n_clks = n[5:0]; tx_data = tx; clk_div = dv; ss_sel = ss; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    tx_data = ~tx; n_clks = 6'd1; clk_div = 8'd0; ss_sel = ~ss; lsb_first = ~lsb;
    check({tag, "_rdy_fall"}, spi_rdy, 1'b0);
    check({tag, "_ssn_fall"}, SS_N, exp_ss);
    lowcnt = 0; ssbad = 1'b0; donebad = 1'b0;
    while (spi_rdy !== 1'b1 && lowcnt < 5000) begin
      if (SS_N !== exp_ss) ssbad = 1'b1;
      if (done !== 1'b0) donebad = 1'b1;
      lowcnt++;
      @(negedge clk);
    end
    check({tag, "_len"}, lowcnt, 1 + 2*h + 2*n*h);
    check({tag, "_ssn_frame"}, ssbad, 1'b0);
    check({tag, "_done_early"}, donebad, 1'b0);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_ssn_end"}, SS_N, 4'hF);
    check({tag, "_rx"}, rx_miso, pat & mask);
    check({tag, "_tx"}, s_rx_word, tx & mask);
    check({tag, "_nbits"}, s_rx_cnt, n);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_sclk_idle_post"}, SCLK, c_pol);
  endtask

  task automatic illegal(input string tag, input logic [5:0] n);
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    n_clks = n; tx_data = 32'hFFFF_FFFF; clk_div = 8'd1; ss_sel = 2'd1; start_cmd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) start_cmd = 1'b0;
      if (spi_rdy !== 1'b1 || SS_N !== 4'hF || done !== 1'b0 || SCLK !== cpol) bad = 1'b1;
    end
    check(tag, bad, 1'b0);
  endtask

  initial begin
    int   guard;
    logic bad;
    areset = 1'b1; start_cmd = 1'b0; n_clks = '0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; clk_div = '0; ss_sel = '0; MISO = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_n = 1; s_miso_pat = '0;
    s_rx_word = '0; s_idx = 0; s_rx_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_rdy", spi_rdy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_ssn", SS_N, 4'hF);
    check("rst_rx", rx_miso, 32'h0);
    areset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("m0", 1'b0, 1'b0, 1'b0, 8, 32'h0000_00A5, 32'h0000_003C, 8'd2, 2'd0);
    run_frame("m1", 1'b0, 1'b1, 1'b0, 32, 32'hDEAD_BEEF, 32'h4B50_4C52, 8'd1, 2'd1);
    run_frame("m2", 1'b1, 1'b0, 1'b0, 32, 32'hDEAD_BEEF, 32'h4B50_4C52, 8'd3, 2'd2);
    run_frame("m3", 1'b1, 1'b1, 1'b0, 32, 32'hDEAD_BEEF, 32'h4B50_4C52, 8'd0, 2'd3);
    run_frame("lsb", 1'b0, 1'b0, 1'b1, 4, 32'h0000_0001, 32'h0000_0001, 8'd1, 2'd0);
    run_frame("lsb_m3", 1'b1, 1'b1, 1'b1, 13, 32'h0000_1A2B, 32'h0000_0F35, 8'd2, 2'd2);
    run_frame("n1", 1'b0, 1'b1, 1'b0, 1, 32'h0000_0001, 32'h0000_0001, 8'd4, 2'd1);

    cpol = 1'b0;
    illegal("ill_n0", 6'd0);
    illegal("ill_n33", 6'd33);
    illegal("ill_n63", 6'd63);

    for (int k = 0; k < 40; k++) begin
      run_frame("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 32)), $urandom, $urandom, 8'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)));
    end

    // Abort a 16-bit frame partway through with an asynchronous reset
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_n = 16; s_miso_pat = 32'h0000_9C3A;
    repeat (2) @(negedge clk);
    s_rx_word = '0; s_rx_cnt = 0; MISO = pat_bit(0); s_idx = 1;
    n_clks = 6'd16; tx_data = 32'h0000_F00D; clk_div = 8'd2; ss_sel = 2'd1; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    guard = 0;
    while (s_rx_cnt < 5 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reach", guard < 1000, 1'b1);
    #2 areset = 1'b1;
    #1;
    check("rst_mid_ssn", SS_N, 4'hF);
    check("rst_mid_sclk", SCLK, 1'b0);
    check("rst_mid_rdy", spi_rdy, 1'b1);
    check("rst_mid_rx", rx_miso, 32'h0);
    check("rst_mid_done", done, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || spi_rdy !== 1'b1 || SS_N !== 4'hF) bad = 1'b1;
    end
    check("rst_mid_quiet", bad, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
